// File: rtl/floo_err_responder.sv
// AXI error slave: accepts every AW/W/AR and answers each with an error B or R response.
// Write and read commands are queued separately; W bursts are counted so they may arrive before their AW.
module floo_err_responder #(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned MaxTxns     = 4,
  parameter bit          AtopSupport = 1'b1,
  parameter logic [1:0]  RespCode    = 2'b11,
  parameter logic [63:0] RespData    = 64'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [5:0]           aw_atop_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 busy_o
);

  localparam int unsigned     PtrW  = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned     CntW  = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] Depth = CntW'(MaxTxns);

  typedef enum logic {IDLE, SEND} r_state_e;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTxns - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IdWidth-1:0] r_wq_id [MaxTxns];
  logic [PtrW-1:0]    r_wq_head, r_wq_tail;
  logic [CntW-1:0]    r_wq_cnt, r_wcnt;
  logic               r_b_valid;

  logic [IdWidth-1:0] r_rq_id  [MaxTxns];
  logic [7:0]         r_rq_len [MaxTxns];
  logic [PtrW-1:0]    r_rq_head, r_rq_tail;
  logic [CntW-1:0]    r_rq_cnt;

  r_state_e           r_state, w_state_nxt;
  logic [7:0]         r_beat, w_beat_nxt;

  logic w_atop_r, w_wq_full, w_rq_full;
  logic w_aw_hs, w_wlast_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_pop;
  logic w_rq_atop_push, w_rq_push, w_have_next;
  logic [CntW-1:0]    w_wq_cnt_nxt, w_wcnt_nxt, w_rq_rem;
  logic [PtrW-1:0]    w_rq_nh;
  logic [IdWidth-1:0] w_push_id;
  logic [7:0]         w_push_len, w_next_len;
  logic               w_unused;

  assign w_unused  = ^aw_atop_i[4:0];
  assign w_atop_r  = AtopSupport && aw_atop_i[5];
  assign w_wq_full = (r_wq_cnt == Depth);
  assign w_rq_full = (r_rq_cnt == Depth);

  assign aw_ready_o = !w_wq_full && (!w_atop_r || !w_rq_full);
  assign w_ready_o  = (r_wcnt < Depth);
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_wlast_hs = w_valid_i && w_ready_o && w_last_i;
  assign w_b_hs     = r_b_valid && b_ready_i;

  assign w_wq_cnt_nxt = r_wq_cnt + CntW'(w_aw_hs) - CntW'(w_b_hs);
  assign w_wcnt_nxt   = r_wcnt + CntW'(w_wlast_hs) - CntW'(w_b_hs);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wq_head <= '0;
      r_wq_tail <= '0;
      r_wq_cnt  <= '0;
      r_wcnt    <= '0;
      r_b_valid <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_wq_id[r_wq_tail] <= aw_id_i;
        r_wq_tail          <= f_inc(r_wq_tail);
      end
      if (w_b_hs) r_wq_head <= f_inc(r_wq_head);
      r_wq_cnt  <= w_wq_cnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_b_valid <= (w_wq_cnt_nxt != '0) && (w_wcnt_nxt != '0);
    end
  end

  assign b_valid_o = r_b_valid;
  assign b_id_o    = r_wq_id[r_wq_head];
  assign b_resp_o  = RespCode;

  // An atomic AW owns the single read-queue write port this cycle, so AR waits.
  assign w_rq_atop_push = w_aw_hs && w_atop_r;
  assign ar_ready_o     = !w_rq_full && !w_rq_atop_push;
  assign w_ar_hs        = ar_valid_i && ar_ready_o;
  assign w_rq_push      = w_rq_atop_push || w_ar_hs;
  assign w_push_id      = w_rq_atop_push ? aw_id_i : ar_id_i;
  assign w_push_len     = w_rq_atop_push ? '0 : ar_len_i;

  assign r_valid_o = (r_state == SEND);
  assign w_r_hs    = r_valid_o && r_ready_i;
  assign w_r_pop   = w_r_hs && (r_beat == '0);

  // Next head after this cycle's pop may be the entry being pushed right now.
  assign w_rq_rem    = r_rq_cnt - CntW'(w_r_pop);
  assign w_rq_nh     = w_r_pop ? f_inc(r_rq_head) : r_rq_head;
  assign w_next_len  = (w_rq_rem != '0) ? r_rq_len[w_rq_nh] : w_push_len;
  assign w_have_next = (w_rq_rem != '0) || w_rq_push;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rq_head <= '0;
      r_rq_tail <= '0;
      r_rq_cnt  <= '0;
    end else begin
      if (w_rq_push) begin
        r_rq_id[r_rq_tail]  <= w_push_id;
        r_rq_len[r_rq_tail] <= w_push_len;
        r_rq_tail           <= f_inc(r_rq_tail);
      end
      if (w_r_pop) r_rq_head <= f_inc(r_rq_head);
      r_rq_cnt <= r_rq_cnt + CntW'(w_rq_push) - CntW'(w_r_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      IDLE: begin
        if (w_have_next) begin
          w_state_nxt = SEND;
          w_beat_nxt  = w_next_len;
        end
      end
      SEND: begin
        if (w_r_hs) begin
          if (r_beat == '0) begin
            if (w_have_next) begin
              w_beat_nxt = w_next_len;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_beat_nxt = r_beat - 8'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign r_last_o = (r_state == SEND) && (r_beat == '0);
  assign r_id_o   = r_rq_id[r_rq_head];
  assign r_data_o = DataWidth'(RespData);
  assign r_resp_o = RespCode;
  assign busy_o   = (r_wq_cnt != '0) || (r_rq_cnt != '0) || (r_wcnt != '0);

endmodule

// File: tb/tb_floo_err_responder.sv
// Random-stimulus bench for floo_err_responder: one instance with atomics enabled, one without,
// both driven by the same inputs and each checked against a queue-based transaction model.
module tb_floo_err_responder;

  localparam int unsigned MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
  logic [3:0] aw_id, ar_id;
  logic [5:0] aw_atop;
  logic [7:0] ar_len;

  logic [1:0]        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, busy;
  logic [1:0][3:0]   b_id, r_id;
  logic [1:0][1:0]   b_resp, r_resp;
  logic [1:0][63:0]  r_data;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    floo_err_responder #(
      .IdWidth    (4),
      .DataWidth  (64),
      .MaxTxns    (MAX),
      .AtopSupport(g == 0),
      .RespCode   (2'b11),
      .RespData   (64'hBADCAB1E)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .aw_valid_i (aw_valid),
      .aw_ready_o (aw_ready[g]),
      .aw_id_i    (aw_id),
      .aw_atop_i  (aw_atop),
      .w_valid_i  (w_valid),
      .w_ready_o  (w_ready[g]),
      .w_last_i   (w_last),
      .b_valid_o  (b_valid[g]),
      .b_ready_i  (b_ready),
      .b_id_o     (b_id[g]),
      .b_resp_o   (b_resp[g]),
      .ar_valid_i (ar_valid),
      .ar_ready_o (ar_ready[g]),
      .ar_id_i    (ar_id),
      .ar_len_i   (ar_len),
      .r_valid_o  (r_valid[g]),
      .r_ready_i  (r_ready),
      .r_id_o     (r_id[g]),
      .r_data_o   (r_data[g]),
      .r_resp_o   (r_resp[g]),
      .r_last_o   (r_last[g]),
      .busy_o     (busy[g])
    );
  end

  // Model: pending B ids, count of completed W bursts, pending R beats encoded as id*2+last.
  int wq    [2][$];
  int beats [2][$];
  int wcnt  [2];
  int rcmds [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit do_check);
    bit haw [2];
    bit hw  [2];
    bit hb  [2];
    bit har [2];
    bit hr  [2];
    bit atr [2];
    bit e_awr, e_wr, e_arr, e_bv, e_rv;
    #1;
    for (int k = 0; k < 2; k++) begin
      atr[k] = (k == 0) && aw_atop[5];
      e_awr  = (wq[k].size() < MAX) && (!atr[k] || rcmds[k] < MAX);
      e_wr   = wcnt[k] < MAX;
      e_arr  = (rcmds[k] < MAX) && !(aw_valid && e_awr && atr[k]);
      e_bv   = (wq[k].size() > 0) && (wcnt[k] > 0);
      e_rv   = beats[k].size() > 0;
      if (do_check) begin
        chk($sformatf("i%0d aw_ready", k), aw_ready[k], e_awr);
        chk($sformatf("i%0d w_ready", k),  w_ready[k],  e_wr);
        chk($sformatf("i%0d ar_ready", k), ar_ready[k], e_arr);
        chk($sformatf("i%0d b_valid", k),  b_valid[k],  e_bv);
        chk($sformatf("i%0d r_valid", k),  r_valid[k],  e_rv);
        chk($sformatf("i%0d busy", k),     busy[k],
            (wq[k].size() > 0) || (rcmds[k] > 0) || (wcnt[k] > 0));
        if (e_bv) begin
          chk($sformatf("i%0d b_id", k),   b_id[k],   wq[k][0]);
          chk($sformatf("i%0d b_resp", k), b_resp[k], 2'b11);
        end
        if (e_rv) begin
          chk($sformatf("i%0d r_id", k),   r_id[k],   beats[k][0] >> 1);
          chk($sformatf("i%0d r_last", k), r_last[k], beats[k][0] & 1);
          chk($sformatf("i%0d r_data", k), r_data[k], 64'hBADCAB1E);
          chk($sformatf("i%0d r_resp", k), r_resp[k], 2'b11);
        end else begin
          chk($sformatf("i%0d r_last idle", k), r_last[k], 1'b0);
        end
      end
      haw[k] = aw_valid && e_awr;
      hw[k]  = w_valid && e_wr && w_last;
      hb[k]  = e_bv && b_ready;
      har[k] = ar_valid && e_arr;
      hr[k]  = e_rv && r_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        wq[k].delete();
        beats[k].delete();
        wcnt[k]  = 0;
        rcmds[k] = 0;
      end else begin
        if (hb[k]) begin
          void'(wq[k].pop_front());
          wcnt[k]--;
        end
        if (hr[k]) begin
          if ((beats[k][0] & 1) != 0) rcmds[k]--;
          void'(beats[k].pop_front());
        end
        if (hw[k]) wcnt[k]++;
        if (haw[k]) begin
          wq[k].push_back(int'(aw_id));
          if (atr[k]) begin
            beats[k].push_back(int'(aw_id) * 2 + 1);
            rcmds[k]++;
          end
        end
        if (har[k]) begin
          for (int i = 0; i <= int'(ar_len); i++)
            beats[k].push_back(int'(ar_id) * 2 + ((i == int'(ar_len)) ? 1 : 0));
          rcmds[k]++;
        end
      end
    end
  endtask

  task automatic idle_in();
    aw_valid = 1'b0; aw_id = '0; aw_atop = '0;
    w_valid  = 1'b0; w_last = 1'b0;
    ar_valid = 1'b0; ar_id = '0; ar_len = '0;
    b_ready  = 1'b1; r_ready = 1'b1;
  endtask

  task automatic rand_in(input int rp, input int bp);
    aw_valid = $urandom_range(0, 99) < 40;
    aw_id    = 4'($urandom);
    aw_atop  = 6'($urandom);
    aw_atop[5] = ($urandom_range(0, 3) == 0);
    w_valid  = $urandom_range(0, 99) < 50;
    w_last   = $urandom_range(0, 1) == 1;
    ar_valid = $urandom_range(0, 99) < 40;
    ar_id    = 4'($urandom);
    ar_len   = ($urandom_range(0, 199) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
    r_ready  = $urandom_range(0, 99) < rp;
    b_ready  = $urandom_range(0, 99) < bp;
  endtask

  initial begin
    int rp, bp;
    for (int k = 0; k < 2; k++) begin
      wcnt[k]  = 0;
      rcmds[k] = 0;
    end
    idle_in();
    rst = 1'b1;
    @(negedge clk); step(1'b0);
    @(negedge clk); step(1'b1);
    rst = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      case ((c / 400) % 4)
        0:       begin rp = 90;  bp = 90;  end
        1:       begin rp = 5;   bp = 10;  end
        2:       begin rp = 50;  bp = 50;  end
        default: begin rp = 100; bp = 100; end
      endcase
      rand_in(rp, bp);
      rst = ($urandom_range(0, 599) == 0);
      step(1'b1);
    end

    // Clean start, then a 256-beat burst cut short by reset after 10 beats.
    @(negedge clk); idle_in(); rst = 1'b1; step(1'b1);
    @(negedge clk); rst = 1'b0; ar_valid = 1'b1; ar_id = 4'd7; ar_len = 8'd255; step(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle_in(); step(1'b1);
    end
    @(negedge clk); rst = 1'b1; step(1'b1);
    @(negedge clk); rst = 1'b0; step(1'b1);

    // Four-beat read, then atomic AW racing an AR, then W last completing the atomic's B.
    @(negedge clk); ar_valid = 1'b1; ar_id = 4'd3; ar_len = 8'd3; step(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_in(); step(1'b1);
    end
    @(negedge clk);
    aw_valid = 1'b1; aw_id = 4'd1; aw_atop = 6'b100000;
    ar_valid = 1'b1; ar_id = 4'd2; ar_len = 8'd0;
    step(1'b1);
    @(negedge clk); aw_valid = 1'b0; aw_atop = '0; step(1'b1);
    @(negedge clk); ar_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1; step(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_in(); step(1'b1);
    end

    // Fill the read queue with replies held off, then drain in order.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle_in(); r_ready = 1'b0;
      ar_valid = 1'b1; ar_id = 4'(i + 8); ar_len = 8'(i % 2);
      step(1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); idle_in(); step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floo_err_responder.md
FLOO_ERR_RESPONDER -- requirements
Module: floo_err_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 4, AXI ID width of all ID ports.
REQ-002 SHALL have parameter DataWidth, default 64, R data width.
REQ-003 SHALL have parameter MaxTxns, default 4, capacity (>=1) of the write and read command queues, each.
REQ-004 SHALL have parameter AtopSupport, default 1, enables atomic (ATOP) R responses.
REQ-005 SHALL have parameter RespCode, default 2'b11 (DECERR), value driven on b_resp_o/r_resp_o.
REQ-006 SHALL have parameter RespData, default 64'hBADCAB1E, zero-extended/truncated to DataWidth for r_data_o.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-008 SHALL have ports: aw_valid_i in 1; aw_ready_o out 1; aw_id_i in IdWidth; aw_atop_i in 6 AXI ATOP field.
REQ-009 SHALL have ports: w_valid_i in 1; w_ready_o out 1; w_last_i in 1.
REQ-010 SHALL have ports: b_valid_o out 1; b_ready_i in 1; b_id_o out IdWidth; b_resp_o out 2.
REQ-011 SHALL have ports: ar_valid_i in 1; ar_ready_o out 1; ar_id_i in IdWidth; ar_len_i in 8 (beats-1).
REQ-012 SHALL have ports: r_valid_o out 1; r_ready_i in 1; r_id_o out IdWidth; r_data_o out DataWidth; r_resp_o out 2; r_last_o out 1.
REQ-013 SHALL have port busy_o out 1, high while any command is queued or any unmatched W burst is counted.

Function
REQ-014 Handshake on any channel SHALL occur in a cycle where valid and ready are both high; valid outputs SHALL not drop or change payload until the handshake.
REQ-015 Write queue: FIFO of {id, atop_r} entries, depth MaxTxns; aw_ready_o = write queue not full AND (if atop_r) read queue not full.
REQ-016 atop_r SHALL be 1 iff AtopSupport=1 and aw_atop_i[5] (ATOP_R_RESP) is 1; with AtopSupport=0 aw_atop_i is ignored.
REQ-017 W counter wcnt (width clog2(MaxTxns+1)) SHALL count completed W bursts not yet matched to a B; w_ready_o = (wcnt < MaxTxns); W beats are sunk, data discarded.
REQ-018 wcnt SHALL increment on a W handshake with w_last_i=1, decrement on a B handshake, and stay unchanged when both occur in the same cycle.
REQ-019 b_valid_o SHALL be registered: high from the cycle after both a write queue head exists and wcnt>0 (W may precede AW); b_id_o = head id; b_resp_o = RespCode.
REQ-020 B handshake SHALL pop the write queue head; a back-to-back B for the next entry SHALL be possible in the following cycle.
REQ-021 Read queue: FIFO of {id, len} entries, depth MaxTxns; an accepted atomic with atop_r=1 SHALL push {aw_id_i, len=0} on its AW handshake.
REQ-022 ar_ready_o SHALL be low when read queue is full or when an atop_r AW handshake occurs in the same cycle (atomic has priority; single push per cycle).
REQ-023 R FSM states IDLE and SEND: IDLE->SEND when read queue non-empty (loads beat counter = head len); r_valid_o high only in SEND.
REQ-024 In SEND each R handshake SHALL decrement the 8-bit beat counter; r_last_o = (counter==0); on last-beat handshake pop head and go to SEND with next head's len if queue non-empty, else IDLE.
REQ-025 r_id_o = head id, r_data_o = RespData, r_resp_o = RespCode for every beat; ar_len_i=255 SHALL yield exactly 256 beats.
REQ-026 Minimum latency: AR handshake at cycle t -> first r_valid_o at t+1; AW and W-last handshakes at t -> b_valid_o at t+1.
REQ-027 Simultaneous push and pop on a full queue SHALL not be allowed to push (ready computed from current full state only).
REQ-028 B and R responses SHALL each return in acceptance order, independent of IDs; B and R channels SHALL be mutually independent.

Reset
REQ-029 On rst_i=1 at a clock edge: both queues empty, wcnt=0, FSM IDLE, beat counter 0; b_valid_o, r_valid_o, r_last_o, busy_o = 0; ready outputs follow REQ-015/017/022 (all 1 after reset).
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further beats; outstanding commands are discarded.

Verification
REQ-031 AR id=3 len=3, r_ready_i=1 -> 4 R beats id=3, resp=2'b11, data=RespData, r_last_o only on beat 4, first beat cycle after AR.
REQ-032 W last before AW (id=5) by 3 cycles -> b_valid_o one cycle after AW handshake, b_id_o=5; busy_o high from W-last to B handshake.
REQ-033 MaxTxns=4: 5 ARs with r_ready_i=0 -> 4 accepted, ar_ready_o low on 5th; release r_ready_i -> responses in order.
REQ-034 Same cycle AW atop=6'b100000 id=1 and AR id=2 -> AW accepted, AR stalled one cycle; single-beat R id=1 precedes R id=2; B id=1 after W last.
REQ-035 AtopSupport=0, AW with atop[5]=1 -> B only, no R beat generated.
REQ-036 Reset during 256-beat burst at beat 10 -> r_valid_o=0 next cycle, busy_o=0, new AR served normally.
